// File: rtl/wb_buffer.sv
// Write-back eviction buffer: queues dirty victim lines and drains them to pmem in FIFO order, with a combinational lookup across queued lines.
// Latency: a request starts one bubble cycle after an entry becomes head. Backpressure: evict_ready is the registered !full, with no pass-through on pop.
module wb_buffer #(
  parameter int WIDTH    = 128,
  parameter int ADDR_W   = 16,
  parameter int OFFSET_W = 4,
  parameter int DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              evict_valid,
  output logic              evict_ready,
  input  logic [ADDR_W-1:0] evict_addr,
  input  logic [WIDTH-1:0]  evict_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_hit,
  output logic [WIDTH-1:0]  lookup_data,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [WIDTH-1:0]  pmem_wdata,
  input  logic              pmem_resp,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int LINE_W = ADDR_W - OFFSET_W;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_e;

  logic [LINE_W-1:0] line_q [DEPTH];
  logic [WIDTH-1:0]  data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_e            state_q, state_d;
  logic              push, pop;
  logic [PTR_W-1:0]  idx;
  logic              unused_low_bits;

  assign unused_low_bits = ^{evict_addr[OFFSET_W-1:0], lookup_addr[OFFSET_W-1:0]};

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign evict_ready = !full;
  assign push        = evict_valid && !full;
  assign pop         = (state_q == WRITE) && pmem_resp;

  always_comb begin
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    vld_d = vld_q;
    if (pop)  vld_d[head_q] = 1'b0;
    if (push) vld_d[tail_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Payload storage needs no reset: every read is qualified by a valid bit or the WRITE state.
  always_ff @(posedge clk) begin
    if (push) begin
      line_q[tail_q] <= evict_addr[ADDR_W-1:OFFSET_W];
      data_q[tail_q] <= evict_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = WRITE;
      WRITE:   if (pmem_resp)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pmem_write   = (state_q == WRITE);
    pmem_address = {line_q[head_q], {OFFSET_W{1'b0}}};
    pmem_wdata   = data_q[head_q];
  end

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (vld_q[idx] && (line_q[idx] == lookup_addr[ADDR_W-1:OFFSET_W])) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_buffer.sv
// Self-checking bench for wb_buffer: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_buffer;
  localparam int WIDTH    = 128;
  localparam int ADDR_W   = 16;
  localparam int OFFSET_W = 4;
  localparam int DEPTH    = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              evict_valid;
  logic              evict_ready;
  logic [ADDR_W-1:0] evict_addr;
  logic [WIDTH-1:0]  evict_data;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [WIDTH-1:0]  lookup_data;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [WIDTH-1:0]  pmem_wdata;
  logic              pmem_resp;
  logic              empty;
  logic              full;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [WIDTH-1:0]  d;
  } ent_t;

  ent_t mq[$];
  bit   m_busy;

  wb_buffer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .evict_addr(evict_addr), .evict_data(evict_data),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Model lookup: youngest queued line whose line address matches.
  function automatic bit m_look(input logic [ADDR_W-1:0] la, output logic [WIDTH-1:0] d);
    d = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a[ADDR_W-1:OFFSET_W] == la[ADDR_W-1:OFFSET_W]) begin
        d = mq[i].d;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // One clock edge with the current inputs; model advances by the queue rules.
  task automatic cycle();
    bit   do_push, do_pop;
    int   n;
    ent_t e, gone;
    n       = mq.size();
    do_push = evict_valid && (n < DEPTH);
    do_pop  = m_busy && pmem_resp;
    e.a     = evict_addr & 16'hFFF0;
    e.d     = evict_data;
    @(posedge clk);
    #1;
    if (do_pop) begin
      gone   = mq.pop_front();
      m_busy = 1'b0;
    end else if (!m_busy && n > 0) begin
      m_busy = 1'b1;
    end
    if (do_push) mq.push_back(e);
  endtask

  task automatic push_line(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    evict_valid = 1'b1;
    evict_addr  = a;
    evict_data  = d;
    cycle();
    evict_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    evict_valid = 1'b0;
    evict_addr  = '0;
    evict_data  = '0;
    lookup_addr = '0;
    pmem_resp   = 1'b0;
    mq.delete();
    m_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain_all();
    pmem_resp = 1'b1;
    for (int c = 0; c < 20 && mq.size() > 0; c++) cycle();
    pmem_resp = 1'b0;
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_timeout empty=%b required=1", empty);
    end
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] d;
    apply_reset();
    checks += 4;
    if (empty !== 1'b1)       begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    if (full !== 1'b0)        begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    if (evict_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", evict_ready); end
    if (pmem_write !== 1'b0)  begin errors++; $display("FAIL reset_pmem_write got=%b exp=0", pmem_write); end
    for (int i = 0; i < 4; i++) begin
      lookup_addr = 16'($urandom());
      #1;
      checks++;
      if (lookup_hit !== 1'b0 || lookup_data !== '0) begin
        errors++;
        $display("FAIL reset_lookup hit=%b data=%h exp hit=0 data=0", lookup_hit, lookup_data);
      end
      void'(m_look(lookup_addr, d));
    end
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] a_dat;
    a_dat = rnd128();
    push_line(16'h1234, a_dat);
    checks++;
    if (pmem_write !== 1'b0) begin errors++; $display("FAIL single_bubble pmem_write=%b exp=0", pmem_write); end
    cycle();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pmem_write !== 1'b1 || pmem_address !== 16'h1230 || pmem_wdata !== a_dat) begin
        errors++;
        $display("FAIL single_req write=%b addr=%h data=%h exp 1 1230 %h", pmem_write, pmem_address, pmem_wdata, a_dat);
      end
      cycle();
    end
    pmem_resp = 1'b1;
    cycle();
    pmem_resp = 1'b0;
    checks++;
    if (empty !== 1'b1 || pmem_write !== 1'b0) begin
      errors++;
      $display("FAIL single_done empty=%b write=%b exp 1 0", empty, pmem_write);
    end
  endtask

  task automatic test_full();
    logic [WIDTH-1:0] da, db, dc;
    logic [ADDR_W-1:0] ea [2];
    logic [WIDTH-1:0]  ed [2];
    int k;
    da = rnd128(); db = rnd128(); dc = rnd128();
    ea[0] = 16'h3000; ea[1] = 16'h4000; ed[0] = db; ed[1] = dc;
    push_line(16'h2000, da);
    push_line(16'h3000, db);
    checks++;
    if (full !== 1'b1 || evict_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_flag full=%b ready=%b exp 1 0", full, evict_ready);
    end
    evict_valid = 1'b1; evict_addr = 16'h4000; evict_data = dc;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (evict_ready !== 1'b0 || pmem_address !== 16'h2000 || pmem_wdata !== da) begin
        errors++;
        $display("FAIL full_hold ready=%b addr=%h exp 0 2000", evict_ready, pmem_address);
      end
      cycle();
    end
    pmem_resp = 1'b1;
    cycle();
    pmem_resp = 1'b0;
    checks++;
    if (evict_ready !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL full_after_pop ready=%b full=%b exp 1 0", evict_ready, full);
    end
    cycle();
    evict_valid = 1'b0;
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL full_third_accept full=%b exp=1", full); end
    k = 0;
    pmem_resp = 1'b1;
    for (int c = 0; c < 40 && k < 2; c++) begin
      if (pmem_write) begin
        checks++;
        if (pmem_address !== ea[k] || pmem_wdata !== ed[k]) begin
          errors++;
          $display("FAIL full_order[%0d] addr=%h exp=%h", k, pmem_address, ea[k]);
        end
        k++;
      end
      cycle();
    end
    pmem_resp = 1'b0;
    checks++;
    if (k != 2) begin errors++; $display("FAIL full_order_timeout writes=%0d exp=2", k); end
  endtask

  task automatic test_lookup();
    logic [WIDTH-1:0] da, db;
    da = rnd128(); db = rnd128();
    push_line(16'h5000, da);
    push_line(16'h500C, db);
    lookup_addr = 16'h5008;
    #1;
    checks++;
    if (lookup_hit !== 1'b1 || lookup_data !== db) begin
      errors++;
      $display("FAIL lookup_youngest hit=%b data=%h exp 1 %h", lookup_hit, lookup_data, db);
    end
    drain_all();
    checks++;
    if (lookup_hit !== 1'b0 || lookup_data !== '0) begin
      errors++;
      $display("FAIL lookup_after_drain hit=%b data=%h exp 0 0", lookup_hit, lookup_data);
    end
  endtask

  task automatic test_push_pop();
    logic [WIDTH-1:0] da, db;
    da = rnd128(); db = rnd128();
    push_line(16'h6000, da);
    cycle();
    evict_valid = 1'b1; evict_addr = 16'h7000; evict_data = db;
    pmem_resp = 1'b1;
    cycle();
    evict_valid = 1'b0;
    pmem_resp = 1'b0;
    checks++;
    if (empty !== 1'b0 || full !== 1'b0 || pmem_write !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_count empty=%b full=%b write=%b exp 0 0 0", empty, full, pmem_write);
    end
    cycle();
    checks++;
    if (pmem_write !== 1'b1 || pmem_address !== 16'h7000 || pmem_wdata !== db) begin
      errors++;
      $display("FAIL pushpop_next write=%b addr=%h exp 1 7000", pmem_write, pmem_address);
    end
    drain_all();
  endtask

  task automatic test_reset_mid();
    push_line(16'h9000, rnd128());
    push_line(16'hA000, rnd128());
    checks++;
    if (pmem_write !== 1'b1) begin errors++; $display("FAIL rstmid_pre write=%b exp=1", pmem_write); end
    #3 rst_n = 1'b0;
    #1;
    mq.delete();
    m_busy = 1'b0;
    checks++;
    if (pmem_write !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async write=%b empty=%b exp 0 1", pmem_write, empty);
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++;
      if (pmem_write !== 1'b0) begin errors++; $display("FAIL rstmid_quiet cyc=%0d write=%b exp=0", i, pmem_write); end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] md;
    bit mh;
    for (int c = 0; c < 400; c++) begin
      evict_valid = ($urandom_range(0, 1) == 1);
      evict_addr  = {12'h800 + 12'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      evict_data  = rnd128();
      pmem_resp   = ($urandom_range(0, 9) < 4);
      lookup_addr = {12'h800 + 12'($urandom_range(0, 4)), 4'($urandom_range(0, 15))};
      #1;
      mh = m_look(lookup_addr, md);
      checks += 4;
      if (empty !== (mq.size() == 0))     begin errors++; $display("FAIL rnd_empty cyc=%0d got=%b", c, empty); end
      if (full !== (mq.size() == DEPTH))  begin errors++; $display("FAIL rnd_full cyc=%0d got=%b", c, full); end
      if (pmem_write !== m_busy)          begin errors++; $display("FAIL rnd_write cyc=%0d got=%b exp=%b", c, pmem_write, m_busy); end
      if (lookup_hit !== mh || lookup_data !== md) begin
        errors++;
        $display("FAIL rnd_lookup cyc=%0d hit=%b data=%h exp %b %h", c, lookup_hit, lookup_data, mh, md);
      end
      if (m_busy) begin
        checks++;
        if (pmem_address !== mq[0].a || pmem_wdata !== mq[0].d) begin
          errors++;
          $display("FAIL rnd_head cyc=%0d addr=%h exp=%h", c, pmem_address, mq[0].a);
        end
      end
      cycle();
    end
    evict_valid = 1'b0;
    drain_all();
  endtask

  initial begin
    rst_n       = 1'b0;
    evict_valid = 1'b0;
    evict_addr  = '0;
    evict_data  = '0;
    lookup_addr = '0;
    pmem_resp   = 1'b0;
    test_reset();
    test_single();
    test_full();
    test_lookup();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
